// File: rtl/dual_issue_steer.sv
// dual_issue_steer
//   Decode-side instruction buffer and pairing unit for the 2-wide pipeline.
//   Fetch pushes up to two {pc, instr} entries per cycle into a small FIFO;
//   the head of the FIFO is presented as a slot0/slot1 issue bundle that the
//   D/X latch consumes. When the head pair may not issue together, only
//   slot0 is offered and split is raised.
//
// Ports
//   clock, ctrl_reset                 clock, async active-low reset
//   fetch_valid0/1, fetch_pc0/1,
//   fetch_instr0/1, fetch_ready       fetch-side push interface
//   dx_stall                          D/X latch not writing this cycle
//   flush                             redirect: drop everything buffered
//   issue_valid0/1, issue_pc0/1,
//   issue_instr0/1, split             issue bundle (combinational from head)
//   occupancy                         entries held
module dual_issue_steer #(
    parameter int DEPTH = 4,
    parameter int PCW   = 32,
    parameter int IW    = 32
) (
    input  logic                     clock,
    input  logic                     ctrl_reset,
    input  logic                     fetch_valid0,
    input  logic                     fetch_valid1,
    input  logic [PCW-1:0]           fetch_pc0,
    input  logic [PCW-1:0]           fetch_pc1,
    input  logic [IW-1:0]            fetch_instr0,
    input  logic [IW-1:0]            fetch_instr1,
    output logic                     fetch_ready,
    input  logic                     dx_stall,
    input  logic                     flush,
    output logic                     issue_valid0,
    output logic                     issue_valid1,
    output logic [PCW-1:0]           issue_pc0,
    output logic [PCW-1:0]           issue_pc1,
    output logic [IW-1:0]            issue_instr0,
    output logic [IW-1:0]            issue_instr1,
    output logic                     split,
    output logic [$clog2(DEPTH):0]   occupancy
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [PCW-1:0] pc_mem    [DEPTH];
    logic [IW-1:0]  instr_mem [DEPTH];

    logic [AW-1:0] rptr;
    logic [AW-1:0] wptr;
    logic [CW-1:0] count;
    logic [AW-1:0] rptr1;
    logic [AW-1:0] wptr1;

    logic          do_push;
    logic          do_pop;
    logic [1:0]    push_cnt;
    logic [1:0]    pop_cnt;
    logic          pair_ok;

    assign rptr1 = rptr + AW'(1);
    assign wptr1 = wptr + AW'(1);

    // ---------------------------------------------------------------
    // Instruction field decode
    // ---------------------------------------------------------------
    function automatic logic is_ctrl(input logic [4:0] op);
        return (op == 5'b00001) || (op == 5'b00010) || (op == 5'b00011) ||
               (op == 5'b00100) || (op == 5'b00110) || (op == 5'b10110);
    endfunction

    function automatic logic is_mem(input logic [4:0] op);
        return (op == 5'b00111) || (op == 5'b01000);
    endfunction

    // Destination register; 0 means "writes nothing visible" since r0 is
    // hardwired and never creates a hazard. jal implicitly writes r31.
    function automatic logic [4:0] dest_reg(input logic [4:0] op,
                                            input logic [4:0] rd);
        logic [4:0] d;
        d = 5'd0;
        if (op == 5'b00000 || op == 5'b00101 || op == 5'b01000)
            d = rd;
        else if (op == 5'b00011)
            d = 5'd31;
        return d;
    endfunction

    logic [IW-1:0] head0;
    logic [IW-1:0] head1;
    logic [4:0]    op0;
    logic [4:0]    op1;
    logic [4:0]    dst0;
    logic [4:0]    dst1;
    logic [4:0]    rs1;
    logic [4:0]    rt1;

    assign head0 = instr_mem[rptr];
    assign head1 = instr_mem[rptr1];
    assign op0   = head0[31:27];
    assign op1   = head1[31:27];
    assign rs1   = head1[21:17];
    assign rt1   = head1[16:12];
    assign dst0  = dest_reg(op0, head0[26:22]);
    assign dst1  = dest_reg(op1, head1[26:22]);

    // Source fields of the younger op are compared regardless of opcode:
    // a spurious split only costs a cycle, a missed hazard corrupts state.
    always_comb begin
        pair_ok = 1'b1;
        if (is_ctrl(op0))
            pair_ok = 1'b0;
        if (is_mem(op0) && is_mem(op1))
            pair_ok = 1'b0;
        if ((dst0 != 5'd0) && ((rs1 == dst0) || (rt1 == dst0)))
            pair_ok = 1'b0;
        if ((dst0 != 5'd0) && (dst1 == dst0))
            pair_ok = 1'b0;
    end

    // ---------------------------------------------------------------
    // Issue bundle and handshake
    // ---------------------------------------------------------------
    assign issue_valid0 = (count >= CW'(1));
    assign issue_valid1 = (count >= CW'(2)) && pair_ok;
    assign split        = (count >= CW'(2)) && !pair_ok;
    assign issue_pc0    = pc_mem[rptr];
    assign issue_pc1    = pc_mem[rptr1];
    assign issue_instr0 = head0;
    assign issue_instr1 = head1;
    assign occupancy    = count;

    assign fetch_ready = (count <= CW'(DEPTH - 2));

    assign do_push  = fetch_ready && !flush;
    assign do_pop   = !dx_stall && !flush;
    assign push_cnt = do_push ? ({1'b0, fetch_valid0} + {1'b0, fetch_valid1}) : 2'd0;
    assign pop_cnt  = do_pop  ? ({1'b0, issue_valid0} + {1'b0, issue_valid1}) : 2'd0;

    // ---------------------------------------------------------------
    // Pointers and count; flush realigns the read side onto the write side
    // ---------------------------------------------------------------
    always_ff @(posedge clock or negedge ctrl_reset) begin
        if (!ctrl_reset) begin
            rptr  <= '0;
            wptr  <= '0;
            count <= '0;
        end else if (flush) begin
            rptr  <= wptr;
            count <= '0;
        end else begin
            wptr  <= wptr + AW'(push_cnt);
            rptr  <= rptr + AW'(pop_cnt);
            count <= count + CW'(push_cnt) - CW'(pop_cnt);
        end
    end

    // Payload storage carries no reset; only the pointers define validity.
    always_ff @(posedge clock) begin
        if (do_push) begin
            if (fetch_valid0) begin
                pc_mem[wptr]    <= fetch_pc0;
                instr_mem[wptr] <= fetch_instr0;
            end
            if (fetch_valid1) begin
                pc_mem[wptr1]    <= fetch_pc1;
                instr_mem[wptr1] <= fetch_instr1;
            end
        end
    end

endmodule

// File: tb/tb_dual_issue_steer.sv
module tb_dual_issue_steer;

    logic        clock;
    logic        ctrl_reset;
    logic        fetch_valid0, fetch_valid1;
    logic [31:0] fetch_pc0, fetch_pc1;
    logic [31:0] fetch_instr0, fetch_instr1;
    logic        fetch_ready;
    logic        dx_stall, flush;
    logic        issue_valid0, issue_valid1;
    logic [31:0] issue_pc0, issue_pc1;
    logic [31:0] issue_instr0, issue_instr1;
    logic        split;
    logic [2:0]  occupancy;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        v1;
        logic [31:0] pc0;
        logic [31:0] in0;
        logic [31:0] pc1;
        logic [31:0] in1;
        logic        sp;
    } exp_t;

    exp_t q[$];

    dual_issue_steer #(.DEPTH(4), .PCW(32), .IW(32)) dut (
        .clock        (clock),
        .ctrl_reset   (ctrl_reset),
        .fetch_valid0 (fetch_valid0),
        .fetch_valid1 (fetch_valid1),
        .fetch_pc0    (fetch_pc0),
        .fetch_pc1    (fetch_pc1),
        .fetch_instr0 (fetch_instr0),
        .fetch_instr1 (fetch_instr1),
        .fetch_ready  (fetch_ready),
        .dx_stall     (dx_stall),
        .flush        (flush),
        .issue_valid0 (issue_valid0),
        .issue_valid1 (issue_valid1),
        .issue_pc0    (issue_pc0),
        .issue_pc1    (issue_pc1),
        .issue_instr0 (issue_instr0),
        .issue_instr1 (issue_instr1),
        .split        (split),
        .occupancy    (occupancy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [31:0] mk(input logic [4:0] op, input logic [4:0] rd,
                                       input logic [4:0] rs, input logic [4:0] rt);
        return {op, rd, rs, rt, 12'h000};
    endfunction

    function automatic exp_t ex(input logic v1, input logic [31:0] pc0, input logic [31:0] in0,
                                input logic [31:0] pc1, input logic [31:0] in1, input logic sp);
        exp_t e;
        e.v1 = v1; e.pc0 = pc0; e.in0 = in0; e.pc1 = pc1; e.in1 = in1; e.sp = sp;
        return e;
    endfunction

    // Monitor: every bundle the D/X latch actually takes is checked in order.
    always @(negedge clock) begin
        if (ctrl_reset && issue_valid0 && !dx_stall && !flush) begin
            exp_t e;
            logic mism;
            total++;
            if (q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_issue got pc0=%0h v1=%0b exp none", issue_pc0, issue_valid1);
            end else begin
                e = q.pop_front();
                mism = (issue_valid1 !== e.v1) || (issue_pc0 !== e.pc0) ||
                       (issue_instr0 !== e.in0) || (split !== e.sp) ||
                       (e.v1 && ((issue_pc1 !== e.pc1) || (issue_instr1 !== e.in1)));
                if (mism) begin
                    bad++;
                    $display("FAIL bundle got v1=%0b pc0=%0h in0=%0h pc1=%0h in1=%0h split=%0b exp v1=%0b pc0=%0h in0=%0h pc1=%0h in1=%0h split=%0b",
                             issue_valid1, issue_pc0, issue_instr0, issue_pc1, issue_instr1, split,
                             e.v1, e.pc0, e.in0, e.pc1, e.in1, e.sp);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic offer(input logic v0, input logic [31:0] p0, input logic [31:0] i0,
                         input logic v1, input logic [31:0] p1, input logic [31:0] i1);
        fetch_valid0 = v0; fetch_pc0 = p0; fetch_instr0 = i0;
        fetch_valid1 = v1; fetch_pc1 = p1; fetch_instr1 = i1;
    endtask

    task automatic idle();
        fetch_valid0 = 1'b0;
        fetch_valid1 = 1'b0;
    endtask

    logic [31:0] ia1, ia2, ib1, ib2, ir2, iz1, iz2, ibne, ilw, isw, iw1, iw2;

    initial begin
        ia1  = mk(5'b00000, 5'd1,  5'd2,  5'd3);
        ia2  = mk(5'b00000, 5'd4,  5'd5,  5'd6);
        ib1  = mk(5'b00000, 5'd7,  5'd8,  5'd9);
        ib2  = mk(5'b00000, 5'd10, 5'd11, 5'd12);
        ir2  = mk(5'b00000, 5'd4,  5'd1,  5'd5);
        iz1  = mk(5'b00000, 5'd0,  5'd2,  5'd3);
        iz2  = mk(5'b00000, 5'd4,  5'd0,  5'd5);
        ibne = mk(5'b00010, 5'd1,  5'd2,  5'd0);
        ilw  = mk(5'b01000, 5'd8,  5'd9,  5'd0);
        isw  = mk(5'b00111, 5'd10, 5'd11, 5'd0);
        iw1  = mk(5'b00000, 5'd3,  5'd1,  5'd2);
        iw2  = mk(5'b00101, 5'd3,  5'd4,  5'd0);

        ctrl_reset = 1'b0;
        dx_stall   = 1'b0;
        flush      = 1'b0;
        offer(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0);

        // reset
        repeat (3) @(posedge clock);
        #1;
        chk("rst_iv0", {31'd0, issue_valid0}, 32'd0);
        chk("rst_iv1", {31'd0, issue_valid1}, 32'd0);
        chk("rst_occ", {29'd0, occupancy}, 32'd0);
        chk("rst_ready", {31'd0, fetch_ready}, 32'd1);
        @(negedge clock);
        ctrl_reset = 1'b1;
        cyc(1);
        chk("post_rst_occ", {29'd0, occupancy}, 32'd0);
        chk("post_rst_iv0", {31'd0, issue_valid0}, 32'd0);

        // independent pair
        q.push_back(ex(1'b1, 32'h10, ia1, 32'h14, ia2, 1'b0));
        offer(1'b1, 32'h10, ia1, 1'b1, 32'h14, ia2);
        cyc(1); idle();
        chk("pair_occ", {29'd0, occupancy}, 32'd2);
        cyc(1);
        chk("pair_drain", {29'd0, occupancy}, 32'd0);

        // RAW split
        q.push_back(ex(1'b0, 32'h20, ia1, 32'h0, 32'h0, 1'b1));
        q.push_back(ex(1'b0, 32'h24, ir2, 32'h0, 32'h0, 1'b0));
        offer(1'b1, 32'h20, ia1, 1'b1, 32'h24, ir2);
        cyc(1); idle();
        cyc(1);
        chk("raw_occ_mid", {29'd0, occupancy}, 32'd1);
        cyc(1);

        // r0 exemption pairs
        q.push_back(ex(1'b1, 32'h30, iz1, 32'h34, iz2, 1'b0));
        offer(1'b1, 32'h30, iz1, 1'b1, 32'h34, iz2);
        cyc(1); idle(); cyc(1);

        // control head splits
        q.push_back(ex(1'b0, 32'h40, ibne, 32'h0, 32'h0, 1'b1));
        q.push_back(ex(1'b0, 32'h44, ib1,  32'h0, 32'h0, 1'b0));
        offer(1'b1, 32'h40, ibne, 1'b1, 32'h44, ib1);
        cyc(1); idle(); cyc(2);

        // two memory ops split
        q.push_back(ex(1'b0, 32'h50, ilw, 32'h0, 32'h0, 1'b1));
        q.push_back(ex(1'b0, 32'h54, isw, 32'h0, 32'h0, 1'b0));
        offer(1'b1, 32'h50, ilw, 1'b1, 32'h54, isw);
        cyc(1); idle(); cyc(2);

        // WAW split
        q.push_back(ex(1'b0, 32'h60, iw1, 32'h0, 32'h0, 1'b1));
        q.push_back(ex(1'b0, 32'h64, iw2, 32'h0, 32'h0, 1'b0));
        offer(1'b1, 32'h60, iw1, 1'b1, 32'h64, iw2);
        cyc(1); idle(); cyc(2);
        chk("split_drain", {29'd0, occupancy}, 32'd0);

        // full FIFO under stall
        dx_stall = 1'b1;
        offer(1'b1, 32'h70, ia1, 1'b1, 32'h74, ia2);
        cyc(1);
        offer(1'b1, 32'h78, ib1, 1'b1, 32'h7c, ib2);
        cyc(1);
        chk("full_occ", {29'd0, occupancy}, 32'd4);
        chk("full_ready", {31'd0, fetch_ready}, 32'd0);
        offer(1'b1, 32'h80, ia1, 1'b1, 32'h84, ia2);
        cyc(1);
        chk("full_ignore", {29'd0, occupancy}, 32'd4);
        idle();
        q.push_back(ex(1'b1, 32'h70, ia1, 32'h74, ia2, 1'b0));
        q.push_back(ex(1'b1, 32'h78, ib1, 32'h7c, ib2, 1'b0));
        dx_stall = 1'b0;
        cyc(2);
        chk("full_drain", {29'd0, occupancy}, 32'd0);

        // flush with push and pop requested together
        dx_stall = 1'b1;
        offer(1'b1, 32'h90, ia1, 1'b1, 32'h94, ia2);
        cyc(1);
        offer(1'b1, 32'h98, ib1, 1'b0, 32'h0, 32'h0);
        cyc(1);
        chk("pre_flush_occ", {29'd0, occupancy}, 32'd3);
        chk("occ3_ready", {31'd0, fetch_ready}, 32'd0);
        offer(1'b1, 32'ha0, ia1, 1'b1, 32'ha4, ia2);
        dx_stall = 1'b0;
        flush    = 1'b1;
        cyc(1);
        flush = 1'b0;
        idle();
        chk("flush_occ", {29'd0, occupancy}, 32'd0);
        chk("flush_iv0", {31'd0, issue_valid0}, 32'd0);
        cyc(1);
        chk("flush_hold", {31'd0, issue_valid0}, 32'd0);

        // pointer wrap after flush
        q.push_back(ex(1'b1, 32'hb0, ib1, 32'hb4, ib2, 1'b0));
        offer(1'b1, 32'hb0, ib1, 1'b1, 32'hb4, ib2);
        cyc(1); idle(); cyc(1);
        chk("wrap_drain", {29'd0, occupancy}, 32'd0);

        // simultaneous push and pop
        q.push_back(ex(1'b1, 32'hc0, ia1, 32'hc4, ia2, 1'b0));
        q.push_back(ex(1'b1, 32'hc8, ib1, 32'hcc, ib2, 1'b0));
        offer(1'b1, 32'hc0, ia1, 1'b1, 32'hc4, ia2);
        cyc(1);
        offer(1'b1, 32'hc8, ib1, 1'b1, 32'hcc, ib2);
        cyc(1);
        chk("pushpop_occ", {29'd0, occupancy}, 32'd2);
        idle();
        cyc(1);
        chk("pushpop_drain", {29'd0, occupancy}, 32'd0);

        // asynchronous reset mid-operation
        dx_stall = 1'b1;
        offer(1'b1, 32'hd0, ia1, 1'b1, 32'hd4, ia2);
        cyc(1); idle();
        chk("pre_arst_occ", {29'd0, occupancy}, 32'd2);
        #2 ctrl_reset = 1'b0;
        #1;
        chk("arst_occ", {29'd0, occupancy}, 32'd0);
        chk("arst_iv0", {31'd0, issue_valid0}, 32'd0);
        chk("arst_ready", {31'd0, fetch_ready}, 32'd1);
        @(negedge clock);
        ctrl_reset = 1'b1;
        dx_stall   = 1'b0;
        cyc(2);
        chk("post_arst_occ", {29'd0, occupancy}, 32'd0);

        chk("queue_empty", q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
